// File: rtl/instr_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit_pkg
// Description : Shared types and constants for the instruction fetch unit.
//               Defines the prefetch queue entry ({pc, instr}) and the
//               helper used to size the credit counters.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_fetch_unit_pkg;

    localparam int c_INSTR_WIDTH = 32;
    // Queue entries carry a full 32-bit PC; the top zero-extends narrower PCs.
    localparam int c_PC_WIDTH    = 32;
    localparam int c_PC_INCR     = 4;

    typedef struct packed {
        logic [c_PC_WIDTH-1:0]    pc;
        logic [c_INSTR_WIDTH-1:0] instr;
    } fetch_queue_entry_t;

    // Width of a counter that must hold values 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_unit_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit_fetch_queue
// Description : Small circular FIFO of fetch_queue_entry_t used as the
//               prefetch buffer. flush has priority over push and pop.
//               Push and pop in the same cycle are allowed, including when
//               the queue is full.
// Ports       : clk, rst_n       clock, async active-low reset
//               push, push_entry write an entry at the tail
//               pop              drop the head entry
//               flush            empty the queue
//               head             current head entry (RESET_ENTRY after reset)
//               count/empty/full occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit_fetch_queue
    import instr_fetch_unit_pkg::*;
#(
    parameter int                 DEPTH       = 2,
    parameter fetch_queue_entry_t RESET_ENTRY = '0,
    parameter int                 CNT_W       = cnt_width(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  fetch_queue_entry_t push_entry,
    input  logic               pop,
    input  logic               flush,
    output fetch_queue_entry_t head,
    output logic [CNT_W-1:0]   count,
    output logic               empty,
    output logic               full
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_queue_entry_t  r_mem [DEPTH];
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]    r_count;

    logic                w_pop;
    logic                w_push;

    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty = (r_count == '0);
    assign full  = (r_count == CNT_W'(DEPTH));
    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

    // A push into a full queue is only taken when the head leaves in the
    // same cycle, so an entry is never overwritten.
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= RESET_ENTRY;
            end
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= push_entry;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Fetch stage ahead of the decoder. Issues sequential word
//               fetches on a valid/ready request port, buffers in-order
//               responses tagged with their PC, and presents them to decode.
//               A redirect pulse flushes the buffer and discards responses
//               that are still in flight.
// Ports       : clk, rst_n                     clock, async active-low reset
//               mem_req_valid/addr/ready        fetch request channel
//               mem_rsp_valid/data              in-order fetch responses
//               redirect_valid/pc               restart fetch at redirect_pc
//               out_valid/instr/pc/ready        decoder channel
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,   // up to 32
    parameter int                    QUEUE_DEPTH = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic                     mem_req_valid,
    output logic [ADDR_WIDTH-1:0]    mem_req_addr,
    input  logic                     mem_req_ready,
    input  logic                     mem_rsp_valid,
    input  logic [c_INSTR_WIDTH-1:0] mem_rsp_data,
    input  logic                     redirect_valid,
    input  logic [ADDR_WIDTH-1:0]    redirect_pc,
    output logic                     out_valid,
    output logic [c_INSTR_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0]    out_pc,
    input  logic                     out_ready
);

    localparam int c_CNT_W = cnt_width(QUEUE_DEPTH);
    localparam int c_SUM_W = c_CNT_W + 1;
    localparam fetch_queue_entry_t c_RESET_ENTRY = '{pc: c_PC_WIDTH'(RESET_PC), instr: '0};

    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic [ADDR_WIDTH-1:0] r_rsp_pc;
    logic [c_CNT_W-1:0]    r_outstanding;
    logic [c_CNT_W-1:0]    r_discard;

    logic [ADDR_WIDTH-1:0] w_redirect_pc;
    logic [c_CNT_W-1:0]    w_q_count;
    logic                  w_q_empty;
    logic                  w_q_full;
    fetch_queue_entry_t    w_head;
    fetch_queue_entry_t    w_push_entry;
    logic                  w_credit;
    logic                  w_req_fire;
    logic                  w_push;
    logic                  w_pop;

    assign w_redirect_pc = redirect_pc & ~ADDR_WIDTH'(2'b11);

    // Buffered plus in-flight fetches may never exceed the queue depth, so
    // every response that is kept is guaranteed a slot. The count used here
    // is registered: a pop from a full queue frees its credit next cycle.
    assign w_credit = (({1'b0, w_q_count} + {1'b0, r_outstanding}) < c_SUM_W'(QUEUE_DEPTH));

    // rst_n is included so the request port reads idle while reset is held.
    assign mem_req_valid = rst_n && !redirect_valid && w_credit;
    assign mem_req_addr  = r_fetch_pc;
    assign w_req_fire    = mem_req_valid && mem_req_ready;

    assign w_push = mem_rsp_valid && !redirect_valid && (r_discard == '0);
    assign w_push_entry = '{pc: c_PC_WIDTH'(r_rsp_pc), instr: mem_rsp_data};

    assign out_valid = !w_q_empty && !redirect_valid;
    assign out_instr = w_head.instr;
    assign out_pc    = w_head.pc[ADDR_WIDTH-1:0];
    assign w_pop     = out_valid && out_ready;

    instr_fetch_unit_fetch_queue #(
        .DEPTH       (QUEUE_DEPTH),
        .RESET_ENTRY (c_RESET_ENTRY),
        .CNT_W       (c_CNT_W)
    ) u_fetch_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (w_push),
        .push_entry (w_push_entry),
        .pop        (w_pop),
        .flush      (redirect_valid),
        .head       (w_head),
        .count      (w_q_count),
        .empty      (w_q_empty),
        .full       (w_q_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            // Every response retires one in-flight request, kept or dropped.
            case ({w_req_fire, mem_rsp_valid})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase

            if (redirect_valid) begin
                r_fetch_pc <= w_redirect_pc;
                r_rsp_pc   <= w_redirect_pc;
                // Everything still in flight after this cycle belongs to the
                // old stream and must be thrown away.
                r_discard  <= r_outstanding - c_CNT_W'(mem_rsp_valid);
            end else begin
                if (w_req_fire) begin
                    r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(c_PC_INCR);
                end
                if (w_push) begin
                    r_rsp_pc <= r_rsp_pc + ADDR_WIDTH'(c_PC_INCR);
                end
                if (mem_rsp_valid && (r_discard != '0)) begin
                    r_discard <= r_discard - 1'b1;
                end
            end
        end
    end

    a_rsp_has_request: assert property (@(posedge clk) disable iff (!rst_n)
        mem_rsp_valid |-> (r_outstanding != '0));

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        w_push |-> (!w_q_full || w_pop));

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Self-checking bench for instr_fetch_unit. A transaction-level
//               model (lists of in-flight fetches and buffered instructions)
//               predicts the DUT outputs every cycle; directed scenarios add
//               hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;

    instr_fetch_unit #(
        .ADDR_WIDTH  (32),
        .QUEUE_DEPTH (2),
        .RESET_PC    (32'h0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int c_DEPTH = 2;

    typedef struct {
        logic [31:0] addr;
        int          cyc;
        bit          dropped;
    } fl_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    fl_t         inflight [$];   // accepted by memory, not yet answered
    ent_t        buffer   [$];   // instructions waiting for decode
    ent_t        pops     [$];   // what the DUT actually handed to decode
    logic [31:0] m_fetch_pc;
    int          cyc;

    int n_checks;
    int n_errors;

    // Stimulus controls for the next step
    bit          drv_redirect;
    logic [31:0] drv_rpc;
    bit          drv_req_ready;
    bit          drv_out_ready;
    bit          mem_stall;

    // Sampled DUT outputs from the most recent step
    logic        s_req_valid;
    logic [31:0] s_req_addr;
    logic        s_out_valid;
    logic [31:0] s_out_pc;
    logic [31:0] s_out_instr;
    int          n_accepts;

    function automatic logic [31:0] wdata(input logic [31:0] a);
        return 32'h1000_0000 + {2'b00, a[31:2]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        inflight.delete();
        buffer.delete();
        m_fetch_pc = 32'h0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " mem_req_valid"}, {31'b0, mem_req_valid}, 32'd0);
        check({tag, " mem_req_addr"},  mem_req_addr,           32'h0);
        check({tag, " out_valid"},     {31'b0, out_valid},     32'd0);
        check({tag, " out_instr"},     out_instr,              32'h0);
        check({tag, " out_pc"},        out_pc,                 32'h0);
    endtask

    // One clock cycle: drive inputs after the falling edge, compare against
    // the model, then advance the model to what the next rising edge does.
    task automatic step();
        bit          exp_req_valid;
        bit          exp_out_valid;
        bit          acc;
        bit          rsp;
        fl_t         it;
        @(negedge clk);
        redirect_valid = drv_redirect;
        redirect_pc    = drv_rpc;
        mem_req_ready  = drv_req_ready;
        out_ready      = drv_out_ready;
        rsp            = !mem_stall && (inflight.size() > 0) && (inflight[0].cyc < cyc);
        mem_rsp_valid  = rsp;
        mem_rsp_data   = rsp ? wdata(inflight[0].addr) : 32'h0;
        #1;

        exp_req_valid = !drv_redirect && ((buffer.size() + inflight.size()) < c_DEPTH);
        exp_out_valid = !drv_redirect && (buffer.size() > 0);
        check("mem_req_valid", {31'b0, mem_req_valid}, {31'b0, exp_req_valid});
        check("mem_req_addr",  mem_req_addr,           m_fetch_pc);
        check("out_valid",     {31'b0, out_valid},     {31'b0, exp_out_valid});
        if (exp_out_valid) begin
            check("out_pc",    out_pc,    buffer[0].pc);
            check("out_instr", out_instr, buffer[0].instr);
        end

        s_req_valid = mem_req_valid;
        s_req_addr  = mem_req_addr;
        s_out_valid = out_valid;
        s_out_pc    = out_pc;
        s_out_instr = out_instr;
        if (mem_req_valid && mem_req_ready) n_accepts++;
        if (out_valid && out_ready) pops.push_back('{pc: out_pc, instr: out_instr});

        acc = exp_req_valid && drv_req_ready;
        if (exp_out_valid && drv_out_ready) void'(buffer.pop_front());
        if (rsp) begin
            it = inflight.pop_front();
            if (!it.dropped && !drv_redirect)
                buffer.push_back('{pc: it.addr, instr: wdata(it.addr)});
        end
        if (acc) begin
            inflight.push_back('{addr: m_fetch_pc, cyc: cyc, dropped: 1'b0});
            m_fetch_pc = m_fetch_pc + 32'd4;
        end
        if (drv_redirect) begin
            buffer.delete();
            foreach (inflight[i]) inflight[i].dropped = 1'b1;
            m_fetch_pc = drv_rpc & ~32'h3;
        end
        drv_redirect = 1'b0;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drain();
        drv_req_ready = 1'b0;
        drv_out_ready = 1'b1;
        mem_stall     = 1'b0;
        run(6);
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        drv_redirect = 1'b1;
        drv_rpc      = pc;
        step();
    endtask

    task automatic check_pop(input int idx, input string name,
                             input logic [31:0] pc, input logic [31:0] instr);
        check({name, " available"}, {31'b0, pops.size() > idx}, 32'd1);
        if (pops.size() > idx) begin
            check({name, " pc"},    pops[idx].pc,    pc);
            check({name, " instr"}, pops[idx].instr, instr);
        end
    endtask

    initial begin
        n_checks = 0; n_errors = 0; cyc = 0; n_accepts = 0;
        drv_redirect = 0; drv_rpc = 0; drv_req_ready = 0; drv_out_ready = 0; mem_stall = 0;
        rst_n = 1'b0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = 0;
        redirect_valid = 0; redirect_pc = 0; out_ready = 0;
        model_reset();

        // Reset values
        @(negedge clk); @(negedge clk); #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Free-running stream from RESET_PC
        drv_req_ready = 1; drv_out_ready = 1;
        pops.delete();
        run(12);
        check_pop(0, "stream0", 32'h0, 32'h1000_0000);
        check_pop(1, "stream1", 32'h4, 32'h1000_0001);
        check_pop(2, "stream2", 32'h8, 32'h1000_0002);

        // Decoder stalled: only QUEUE_DEPTH fetches go out, head is held
        drain();
        drv_req_ready = 1; drv_out_ready = 0;
        redirect_to(32'h200);
        n_accepts = 0;
        run(10);
        check("stall accepts",  n_accepts, 32'd2);
        check("stall head pc",  s_out_pc, 32'h200);
        check("stall head instr", s_out_instr, 32'h1000_0080);
        check("stall req_valid", {31'b0, s_req_valid}, 32'd0);
        check("stall req_addr", s_req_addr, 32'h208);
        drv_out_ready = 1;
        step();
        check("pop cycle req_valid", {31'b0, s_req_valid}, 32'd0);
        drv_out_ready = 0;
        step();
        check("after pop req_valid", {31'b0, s_req_valid}, 32'd1);
        check("after pop req_addr", s_req_addr, 32'h208);

        // Redirect with two responses in flight
        drain();
        mem_stall = 1; drv_req_ready = 1; drv_out_ready = 1;
        run(2);
        redirect_to(32'h0000_0103);
        mem_stall = 0;
        pops.delete();
        step();
        check("redir req_addr", s_req_addr, 32'h100);
        run(8);
        check_pop(0, "redir first", 32'h100, 32'h1000_0040);

        // Redirect colliding with a response and a pop
        drain();
        drv_req_ready = 1; drv_out_ready = 0; mem_stall = 1;
        redirect_to(32'h300);
        run(2);
        mem_stall = 0;
        step();
        drv_out_ready = 1;
        redirect_to(32'h400);
        check("collide out_valid", {31'b0, s_out_valid}, 32'd0);
        pops.delete();
        step();
        check("post collide out_valid", {31'b0, s_out_valid}, 32'd0);
        check("post collide req_valid", {31'b0, s_req_valid}, 32'd1);
        check("post collide req_addr",  s_req_addr, 32'h400);
        run(6);
        check_pop(0, "collide first", 32'h400, 32'h1000_0100);

        // Address wrap
        drain();
        drv_req_ready = 1; drv_out_ready = 1;
        redirect_to(32'hFFFF_FFFC);
        pops.delete();
        step();
        check("wrap req_addr top", s_req_addr, 32'hFFFF_FFFC);
        step();
        check("wrap req_addr zero", s_req_addr, 32'h0);
        run(8);
        check_pop(0, "wrap a", 32'hFFFF_FFFC, 32'h4FFF_FFFF);
        check_pop(1, "wrap b", 32'h0, 32'h1000_0000);

        // Asynchronous reset with the queue full
        drv_out_ready = 0;
        run(6);
        check("full out_valid", {31'b0, s_out_valid}, 32'd1);
        check("full req_valid", {31'b0, s_req_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        mem_req_ready = 0; mem_rsp_valid = 0; out_ready = 0; redirect_valid = 0;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drv_req_ready = 1; drv_out_ready = 1;
        pops.delete();
        run(10);
        check_pop(0, "restart0", 32'h0, 32'h1000_0000);
        check_pop(1, "restart1", 32'h4, 32'h1000_0001);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
